// File: rtl/mag_cmp_8bit.sv
// 8-bit unsigned magnitude comparator with 7485-style g/e/l cascade inputs.
// Two cascaded 4-bit stages feed a single rank of result flops.
module mag_cmp_8bit (
   input  logic clk,
   input  logic rst,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic a3,
   input  logic a4,
   input  logic a5,
   input  logic a6,
   input  logic a7,
   input  logic b0,
   input  logic b1,
   input  logic b2,
   input  logic b3,
   input  logic b4,
   input  logic b5,
   input  logic b6,
   input  logic b7,
   input  logic g,
   input  logic e,
   input  logic l,
   output logic gt,
   output logic eq,
   output logic lt
);

   logic [7:0] a_vec;
   logic [7:0] b_vec;
   logic       lo_gt, lo_eq, lo_lt;
   logic       gt_d, eq_d, lt_d;
   logic       gt_q, eq_q, lt_q;

   assign a_vec = {a7, a6, a5, a4, a3, a2, a1, a0};
   assign b_vec = {b7, b6, b5, b4, b3, b2, b1, b0};

   // One 7485 stage; an equal nibble defers to the cascade, with e dominant.
   function automatic logic [2:0] cmp_stage(
      input logic [3:0] a_nib,
      input logic [3:0] b_nib,
      input logic       c_gt,
      input logic       c_eq,
      input logic       c_lt
   );
      logic [2:0] res;
      if (a_nib > b_nib)
         res = 3'b100;
      else if (a_nib < b_nib)
         res = 3'b001;
      else
         res = {c_gt & ~c_eq, c_eq, c_lt & ~c_eq};
      return res;
   endfunction

   always_comb begin
      {lo_gt, lo_eq, lo_lt} = cmp_stage(a_vec[3:0], b_vec[3:0], g, e, l);
      {gt_d, eq_d, lt_d}    = cmp_stage(a_vec[7:4], b_vec[7:4], lo_gt, lo_eq, lo_lt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gt_q <= 1'b0;
         eq_q <= 1'b0;
         lt_q <= 1'b0;
      end else begin
         gt_q <= gt_d;
         eq_q <= eq_d;
         lt_q <= lt_d;
      end
   end

   assign gt = gt_q;
   assign eq = eq_q;
   assign lt = lt_q;

endmodule

// File: tb/tb_mag_cmp_8bit.sv
// Directed self-checking bench for mag_cmp_8bit; results are packed {gt,eq,lt}.
module tb_mag_cmp_8bit;

   logic       clk;
   logic       rst;
   logic [7:0] a_v;
   logic [7:0] b_v;
   logic       g_v, e_v, l_v;
   logic       gt, eq, lt;
   int         total;
   int         bad;

   mag_cmp_8bit dut (
      .clk(clk), .rst(rst),
      .a0(a_v[0]), .a1(a_v[1]), .a2(a_v[2]), .a3(a_v[3]),
      .a4(a_v[4]), .a5(a_v[5]), .a6(a_v[6]), .a7(a_v[7]),
      .b0(b_v[0]), .b1(b_v[1]), .b2(b_v[2]), .b3(b_v[3]),
      .b4(b_v[4]), .b5(b_v[5]), .b6(b_v[6]), .b7(b_v[7]),
      .g(g_v), .e(e_v), .l(l_v),
      .gt(gt), .eq(eq), .lt(lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic gi, input logic ei, input logic li);
      a_v = a; b_v = b; g_v = gi; e_v = ei; l_v = li;
   endtask

   task automatic test_reset;
      logic [2:0] obs;
      rst = 1'b1;
      drive(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b1);
      #3;
      obs = {gt, eq, lt};
      total++;
      if (obs !== 3'b000) begin
         bad++;
         $display("FAIL reset_initial got=%b want=000", obs);
      end
      repeat (2) @(posedge clk);
      #1;
      obs = {gt, eq, lt};
      total++;
      if (obs !== 3'b000) begin
         bad++;
         $display("FAIL reset_held got=%b want=000", obs);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      obs = {gt, eq, lt};
      total++;
      if (obs !== 3'b100) begin
         bad++;
         $display("FAIL reset_release_first got=%b want=100", obs);
      end
   endtask

   task automatic test_zero;
      logic [2:0] obs;
      @(negedge clk);
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      obs = {gt, eq, lt};
      total++;
      if (obs !== 3'b000) begin
         bad++;
         $display("FAIL zero_no_cascade got=%b want=000", obs);
      end
   endtask

   task automatic test_msb;
      logic [2:0] obs;
      @(negedge clk);
      drive(8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      obs = {gt, eq, lt};
      total++;
      if (obs !== 3'b001) begin
         bad++;
         $display("FAIL msb_dominates got=%b want=001", obs);
      end
   endtask

   task automatic test_cascade;
      logic [2:0] obs;
      logic [2:0] casc [6];
      logic [2:0] want [6];
      casc[0] = 3'b010; want[0] = 3'b010;
      casc[1] = 3'b100; want[1] = 3'b100;
      casc[2] = 3'b001; want[2] = 3'b001;
      casc[3] = 3'b101; want[3] = 3'b101;
      casc[4] = 3'b111; want[4] = 3'b010;
      casc[5] = 3'b000; want[5] = 3'b000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(8'hA5, 8'hA5, casc[i][2], casc[i][1], casc[i][0]);
         @(posedge clk);
         #1;
         obs = {gt, eq, lt};
         total++;
         if (obs !== want[i]) begin
            bad++;
            $display("FAIL cascade_equal gel=%b got=%b want=%b", casc[i], obs, want[i]);
         end
      end
   endtask

   task automatic test_override;
      logic [2:0] obs;
      logic [7:0] av   [4];
      logic [7:0] bv   [4];
      logic [2:0] casc [4];
      logic [2:0] want [4];
      av[0] = 8'h80; bv[0] = 8'h7F; casc[0] = 3'b010; want[0] = 3'b100;
      av[1] = 8'h10; bv[1] = 8'h1F; casc[1] = 3'b100; want[1] = 3'b001;
      av[2] = 8'h1F; bv[2] = 8'h10; casc[2] = 3'b011; want[2] = 3'b100;
      av[3] = 8'h37; bv[3] = 8'h38; casc[3] = 3'b110; want[3] = 3'b001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(av[i], bv[i], casc[i][2], casc[i][1], casc[i][0]);
         @(posedge clk);
         #1;
         obs = {gt, eq, lt};
         total++;
         if (obs !== want[i]) begin
            bad++;
            $display("FAIL override a=%h b=%h got=%b want=%b", av[i], bv[i], obs, want[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] obs;
      logic [7:0] av   [7];
      logic [7:0] bv   [7];
      logic [2:0] casc [7];
      logic [2:0] want [7];
      av[0] = 8'h12; bv[0] = 8'h34; casc[0] = 3'b010; want[0] = 3'b001;
      av[1] = 8'hFF; bv[1] = 8'h00; casc[1] = 3'b001; want[1] = 3'b100;
      av[2] = 8'h5A; bv[2] = 8'h5A; casc[2] = 3'b100; want[2] = 3'b100;
      av[3] = 8'h00; bv[3] = 8'hFF; casc[3] = 3'b100; want[3] = 3'b001;
      av[4] = 8'h7F; bv[4] = 8'h7F; casc[4] = 3'b010; want[4] = 3'b010;
      av[5] = 8'hF0; bv[5] = 8'h0F; casc[5] = 3'b000; want[5] = 3'b100;
      av[6] = 8'h0F; bv[6] = 8'hF0; casc[6] = 3'b000; want[6] = 3'b001;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i > 0) begin
            obs = {gt, eq, lt};
            total++;
            if (obs !== want[i-1]) begin
               bad++;
               $display("FAIL b2b_hold idx=%0d got=%b want=%b", i - 1, obs, want[i-1]);
            end
         end
         drive(av[i], bv[i], casc[i][2], casc[i][1], casc[i][0]);
         @(posedge clk);
         #1;
         obs = {gt, eq, lt};
         total++;
         if (obs !== want[i]) begin
            bad++;
            $display("FAIL b2b_result idx=%0d got=%b want=%b", i, obs, want[i]);
         end
      end
      #1;
      rst = 1'b1;
      #1;
      obs = {gt, eq, lt};
      total++;
      if (obs !== 3'b000) begin
         bad++;
         $display("FAIL b2b_async_reset got=%b want=000", obs);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(8'h44, 8'h44, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      obs = {gt, eq, lt};
      total++;
      if (obs !== 3'b010) begin
         bad++;
         $display("FAIL b2b_after_reset got=%b want=010", obs);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_zero();
      test_msb();
      test_cascade();
      test_override();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
